// File: rtl/lsu_bus_bridge_pkg.sv
// Shared types for the load/store bridge: funct3 size codes, fault codes and FSM states.
// size_legal() is the single definition of which sizes a given bus width can carry.
package lsu_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_D  = 3'b011;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;
  localparam logic [2:0] SZ_WU = 3'b110;

  typedef enum logic [1:0] {
    FLT_MISALIGN = 2'b00,
    FLT_ILLSIZE  = 2'b01,
    FLT_BUSERR   = 2'b10,
    FLT_TIMEOUT  = 2'b11
  } fault_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10,
    ST_RESP = 2'b11
  } state_e;

  function automatic logic size_legal(input logic [2:0] sz, input int data_w);
    case (sz)
      SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU: return 1'b1;
      SZ_D, SZ_WU:                    return (data_w == 64);
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_bus_bridge_if.sv
// Core-side and bus-side bundles of the load/store bridge.
// The core is master of lsu_core_if; the bridge is master of lsu_mem_if.
interface lsu_core_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              req_valid;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [2:0]        req_size;
  logic              stall;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              fault;
  logic [1:0]        fault_code;

  modport master (output req_valid, req_we, req_addr, req_wdata, req_size,
                  input  stall, rsp_valid, rsp_rdata, fault, fault_code);
  modport slave  (input  req_valid, req_we, req_addr, req_wdata, req_size,
                  output stall, rsp_valid, rsp_rdata, fault, fault_code);
endinterface

interface lsu_mem_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic                bus_valid;
  logic                bus_ready;
  logic                bus_we;
  logic [ADDR_W-1:0]   bus_addr;
  logic [DATA_W-1:0]   bus_wdata;
  logic [DATA_W/8-1:0] bus_be;
  logic                bus_rvalid;
  logic [DATA_W-1:0]   bus_rdata;
  logic                bus_err;

  modport master (output bus_valid, bus_we, bus_addr, bus_wdata, bus_be,
                  input  bus_ready, bus_rvalid, bus_rdata, bus_err);
  modport slave  (input  bus_valid, bus_we, bus_addr, bus_wdata, bus_be,
                  output bus_ready, bus_rvalid, bus_rdata, bus_err);
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store shift and byte enables, load extract and
// sign/zero extension, plus the size legality and alignment checks.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int BE_W   = DATA_W / 8,
  localparam int OFF_W  = $clog2(BE_W)
) (
  input  logic [2:0]        i_size,
  input  logic [OFF_W-1:0]  i_off,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              o_illegal,
  output logic              o_misalign,
  output logic [DATA_W-1:0] o_wdata,
  output logic [BE_W-1:0]   o_be,
  output logic [DATA_W-1:0] o_rdata
);

  logic [BE_W-1:0]   w_mask;
  logic [OFF_W-1:0]  w_amask;
  logic [DATA_W-1:0] w_keep;
  logic [DATA_W-1:0] w_rshift;
  logic              w_sign_bit;
  logic              w_sign;

  assign w_rshift = i_rdata >> {i_off, 3'b000};

  // Size 11 on a 32-bit bus is flagged illegal, so its all-ones values never reach the bus.
  always_comb begin
    w_mask     = '0;
    w_amask    = '0;
    w_keep     = '0;
    w_sign_bit = 1'b0;
    case (i_size[1:0])
      2'd0: begin
        w_mask     = BE_W'(1);
        w_amask    = '0;
        w_keep     = DATA_W'(8'hFF);
        w_sign_bit = w_rshift[7];
      end
      2'd1: begin
        w_mask     = BE_W'(3);
        w_amask    = OFF_W'(1);
        w_keep     = DATA_W'(16'hFFFF);
        w_sign_bit = w_rshift[15];
      end
      2'd2: begin
        w_mask     = BE_W'(15);
        w_amask    = OFF_W'(3);
        w_keep     = DATA_W'(32'hFFFF_FFFF);
        w_sign_bit = w_rshift[31];
      end
      default: begin
        w_mask     = {BE_W{1'b1}};
        w_amask    = OFF_W'(7);
        w_keep     = '1;
        w_sign_bit = w_rshift[DATA_W-1];
      end
    endcase
  end

  assign w_sign     = ~i_size[2] & w_sign_bit;
  assign o_rdata    = (w_rshift & w_keep) | ({DATA_W{w_sign}} & ~w_keep);
  assign o_wdata    = i_wdata << {i_off, 3'b000};
  assign o_be       = w_mask << i_off;
  assign o_illegal  = ~size_legal(i_size, DATA_W);
  assign o_misalign = |(i_off & w_amask);

endmodule

// File: rtl/lsu_bus_bridge.sv
// Stalls the core while one load/store runs over a valid/ready bus with wait states,
// reporting misalignment, illegal size, bus error and timeout as faults.
//
// state | meaning
// IDLE  | waiting for req_valid; stall follows req_valid
// ADDR  | bus_valid high, waiting for bus_ready
// DATA  | request accepted, waiting for bus_rvalid
// RESP  | one-cycle rsp_valid, core commits
module lsu_bus_bridge
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input logic       clk,
  input logic       reset,
  lsu_core_if.slave core,
  lsu_mem_if.master mem
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_e            r_state;
  logic [TMO_W-1:0]  r_tmo;
  logic              r_bus_valid;
  logic              r_bus_we;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_wdata;
  logic [BE_W-1:0]   r_bus_be;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_fault;
  fault_e            r_fault_code;

  logic              w_illegal;
  logic              w_misalign;
  logic [DATA_W-1:0] w_wdata_sh;
  logic [BE_W-1:0]   w_be;
  logic [DATA_W-1:0] w_rdata_ext;
  logic [DATA_W-1:0] w_rsp_data;
  logic              w_tmo_hit;

  // The core holds its request while stalled, so the live offset also steers the read data.
  lsu_lane_align #(.DATA_W(DATA_W)) u_align (
    .i_size     (core.req_size),
    .i_off      (core.req_addr[OFF_W-1:0]),
    .i_wdata    (core.req_wdata),
    .i_rdata    (mem.bus_rdata),
    .o_illegal  (w_illegal),
    .o_misalign (w_misalign),
    .o_wdata    (w_wdata_sh),
    .o_be       (w_be),
    .o_rdata    (w_rdata_ext)
  );

  assign w_rsp_data = (mem.bus_err | core.req_we) ? '0 : w_rdata_ext;
  assign w_tmo_hit  = (r_tmo == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_tmo        <= '0;
      r_bus_valid  <= 1'b0;
      r_bus_we     <= 1'b0;
      r_bus_addr   <= '0;
      r_bus_wdata  <= '0;
      r_bus_be     <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_fault      <= 1'b0;
      r_fault_code <= FLT_MISALIGN;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (core.req_valid) begin
            if (w_illegal || w_misalign) begin
              r_state      <= ST_RESP;
              r_rsp_valid  <= 1'b1;
              r_rsp_rdata  <= '0;
              r_fault      <= 1'b1;
              r_fault_code <= w_illegal ? FLT_ILLSIZE : FLT_MISALIGN;
            end else begin
              r_state     <= ST_ADDR;
              r_tmo       <= '0;
              r_bus_valid <= 1'b1;
              r_bus_we    <= core.req_we;
              r_bus_addr  <= {core.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              r_bus_wdata <= w_wdata_sh;
              r_bus_be    <= w_be;
            end
          end
        end
        ST_ADDR: begin
          r_tmo <= r_tmo + TMO_W'(1);
          if (mem.bus_ready && mem.bus_rvalid) begin
            r_state      <= ST_RESP;
            r_bus_valid  <= 1'b0;
            r_rsp_valid  <= 1'b1;
            r_rsp_rdata  <= w_rsp_data;
            r_fault      <= mem.bus_err;
            r_fault_code <= FLT_BUSERR;
          end else if (w_tmo_hit) begin
            r_state      <= ST_RESP;
            r_bus_valid  <= 1'b0;
            r_rsp_valid  <= 1'b1;
            r_rsp_rdata  <= '0;
            r_fault      <= 1'b1;
            r_fault_code <= FLT_TIMEOUT;
          end else if (mem.bus_ready) begin
            r_state     <= ST_DATA;
            r_bus_valid <= 1'b0;
          end
        end
        ST_DATA: begin
          r_tmo <= r_tmo + TMO_W'(1);
          if (mem.bus_rvalid) begin
            r_state      <= ST_RESP;
            r_rsp_valid  <= 1'b1;
            r_rsp_rdata  <= w_rsp_data;
            r_fault      <= mem.bus_err;
            r_fault_code <= FLT_BUSERR;
          end else if (w_tmo_hit) begin
            r_state      <= ST_RESP;
            r_rsp_valid  <= 1'b1;
            r_rsp_rdata  <= '0;
            r_fault      <= 1'b1;
            r_fault_code <= FLT_TIMEOUT;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_rsp_valid  <= 1'b0;
          r_rsp_rdata  <= '0;
          r_fault      <= 1'b0;
          r_fault_code <= FLT_MISALIGN;
        end
      endcase
    end
  end

  assign core.stall      = (r_state == ST_IDLE) ? core.req_valid : (r_state != ST_RESP);
  assign core.rsp_valid  = r_rsp_valid;
  assign core.rsp_rdata  = r_rsp_rdata;
  assign core.fault      = r_fault;
  assign core.fault_code = r_fault_code;
  assign mem.bus_valid   = r_bus_valid;
  assign mem.bus_we      = r_bus_we;
  assign mem.bus_addr    = r_bus_addr;
  assign mem.bus_wdata   = r_bus_wdata;
  assign mem.bus_be      = r_bus_be;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Directed bench for lsu_bus_bridge at DATA_W=32 and DATA_W=64, with a response scoreboard
// and a small bus responder that answers one cycle after acceptance.
module tb_lsu_bus_bridge;

  typedef struct {
    logic [63:0] rdata;
    logic        fault;
    logic [1:0]  code;
    int          stalls;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        t_sel;
  logic        t_valid;
  logic        t_we;
  logic [31:0] t_addr;
  logic [63:0] t_wdata;
  logic [2:0]  t_size;
  logic        m_ready;
  logic        m_err;
  logic        m_auto;
  logic        m_force;
  logic [63:0] m_rdata;
  logic        p32 = 1'b0, r32 = 1'b0, p64 = 1'b0, r64 = 1'b0;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];

  int          nbus;
  logic [31:0] cap_addr;
  logic [7:0]  cap_be;
  logic [63:0] cap_wdata;
  logic        cap_we;

  lsu_core_if #(.ADDR_W(32), .DATA_W(32)) c32 ();
  lsu_mem_if  #(.ADDR_W(32), .DATA_W(32)) m32 ();
  lsu_core_if #(.ADDR_W(32), .DATA_W(64)) c64 ();
  lsu_mem_if  #(.ADDR_W(32), .DATA_W(64)) m64 ();

  lsu_bus_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) u_dut32 (
    .clk(clk), .reset(rst_n), .core(c32), .mem(m32));
  lsu_bus_bridge #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(16)) u_dut64 (
    .clk(clk), .reset(rst_n), .core(c64), .mem(m64));

  assign c32.req_valid = t_valid & ~t_sel;
  assign c32.req_we    = t_we;
  assign c32.req_addr  = t_addr;
  assign c32.req_wdata = t_wdata[31:0];
  assign c32.req_size  = t_size;
  assign c64.req_valid = t_valid & t_sel;
  assign c64.req_we    = t_we;
  assign c64.req_addr  = t_addr;
  assign c64.req_wdata = t_wdata;
  assign c64.req_size  = t_size;

  assign m32.bus_ready  = m_ready;
  assign m32.bus_err    = m_err;
  assign m32.bus_rdata  = m_rdata[31:0];
  assign m32.bus_rvalid = r32 | m_force;
  assign m64.bus_ready  = m_ready;
  assign m64.bus_err    = m_err;
  assign m64.bus_rdata  = m_rdata;
  assign m64.bus_rvalid = r64 | m_force;

  // Response goes out during the cycle after the request was accepted.
  always @(negedge clk) begin
    r32 = p32;
    p32 = m32.bus_valid & m32.bus_ready & m_auto;
    r64 = p64;
    p64 = m64.bus_valid & m64.bus_ready & m_auto;
  end

  logic        o_stall, o_rsp_valid, o_fault, o_bus_valid, o_bus_we;
  logic [1:0]  o_code;
  logic [63:0] o_rdata, o_bus_wdata;
  logic [31:0] o_bus_addr;
  logic [7:0]  o_bus_be;

  assign o_stall     = t_sel ? c64.stall      : c32.stall;
  assign o_rsp_valid = t_sel ? c64.rsp_valid  : c32.rsp_valid;
  assign o_fault     = t_sel ? c64.fault      : c32.fault;
  assign o_code      = t_sel ? c64.fault_code : c32.fault_code;
  assign o_rdata     = t_sel ? c64.rsp_rdata  : {32'h0, c32.rsp_rdata};
  assign o_bus_valid = t_sel ? m64.bus_valid  : m32.bus_valid;
  assign o_bus_we    = t_sel ? m64.bus_we     : m32.bus_we;
  assign o_bus_addr  = t_sel ? m64.bus_addr   : m32.bus_addr;
  assign o_bus_be    = t_sel ? m64.bus_be     : {4'h0, m32.bus_be};
  assign o_bus_wdata = t_sel ? m64.bus_wdata  : {32'h0, m32.bus_wdata};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] rdata, input logic fault,
                              input logic [1:0] code, input int stalls);
    exp_t e;
    e.rdata  = rdata;
    e.fault  = fault;
    e.code   = code;
    e.stalls = stalls;
    return e;
  endfunction

  task automatic run(input string tag, input logic sel, input logic we,
                     input logic [31:0] addr, input logic [63:0] wdata,
                     input logic [2:0] size, input logic [63:0] rdata_in, input exp_t e);
    exp_t want;
    int   stalls;
    logic done;
    sb.push_back(e);
    @(negedge clk);
    t_sel = sel; t_we = we; t_addr = addr; t_wdata = wdata; t_size = size;
    m_rdata = rdata_in; t_valid = 1'b1;
    stalls = 0; nbus = 0; done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      #1;
      if (o_rsp_valid) begin
        done = 1'b1;
      end else begin
        if (o_stall) stalls++;
        if (o_bus_valid) begin
          nbus++;
          cap_addr = o_bus_addr; cap_be = o_bus_be;
          cap_wdata = o_bus_wdata; cap_we = o_bus_we;
        end
        @(negedge clk);
      end
    end
    chk({tag, " rsp_seen"}, 64'(done), 64'(1));
    if (done) begin
      want = sb.pop_front();
      chk({tag, " rdata"}, o_rdata, want.rdata);
      chk({tag, " fault"}, 64'(o_fault), 64'(want.fault));
      if (want.fault) chk({tag, " code"}, 64'(o_code), 64'(want.code));
      chk({tag, " stalls"}, 64'(stalls), 64'(want.stalls));
      chk({tag, " stall_in_resp"}, 64'(o_stall), 64'(0));
    end else begin
      void'(sb.pop_front());
    end
    t_valid = 1'b0;
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; t_sel = 1'b0; t_valid = 1'b0; t_we = 1'b0; t_addr = '0;
    t_wdata = '0; t_size = '0; m_ready = 1'b1; m_err = 1'b0; m_auto = 1'b1;
    m_force = 1'b0; m_rdata = '0;
    #3;
    chk("rst stall32",  64'(c32.stall), 64'(0));
    chk("rst rsp32",    64'(c32.rsp_valid), 64'(0));
    chk("rst bv32",     64'(m32.bus_valid), 64'(0));
    chk("rst be32",     64'(m32.bus_be), 64'(0));
    chk("rst bv64",     64'(m64.bus_valid), 64'(0));
    chk("rst rdata64",  c64.rsp_rdata, 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    run("SW", 1'b0, 1'b1, 32'h100, 64'hDEADBEEF, 3'b010, 64'h0, mk(64'h0, 1'b0, 2'b00, 3));
    chk("SW bus_addr",  64'(cap_addr), 64'h100);
    chk("SW bus_be",    64'(cap_be), 64'hF);
    chk("SW bus_wdata", cap_wdata, 64'hDEADBEEF);
    chk("SW bus_we",    64'(cap_we), 64'(1));
    chk("SW nbus",      64'(nbus), 64'(1));

    run("LB",  1'b0, 1'b0, 32'h103, 64'h0, 3'b000, 64'h80123456, mk(64'hFFFFFF80, 1'b0, 2'b00, 3));
    chk("LB bus_we",    64'(cap_we), 64'(0));
    run("LBU", 1'b0, 1'b0, 32'h103, 64'h0, 3'b100, 64'h80123456, mk(64'h00000080, 1'b0, 2'b00, 3));
    run("LHU", 1'b0, 1'b0, 32'h102, 64'h0, 3'b101, 64'h80010000, mk(64'h00008001, 1'b0, 2'b00, 3));

    run("SH", 1'b0, 1'b1, 32'h102, 64'h1234, 3'b001, 64'h0, mk(64'h0, 1'b0, 2'b00, 3));
    chk("SH bus_addr",  64'(cap_addr), 64'h100);
    chk("SH bus_be",    64'(cap_be), 64'hC);
    chk("SH bus_wdata", cap_wdata, 64'h12340000);

    run("LW mis", 1'b0, 1'b0, 32'h101, 64'h0, 3'b010, 64'h55555555, mk(64'h0, 1'b1, 2'b00, 1));
    chk("LW mis nbus", 64'(nbus), 64'(0));
    run("LD ill", 1'b0, 1'b0, 32'h100, 64'h0, 3'b011, 64'h55555555, mk(64'h0, 1'b1, 2'b01, 1));
    chk("LD ill nbus", 64'(nbus), 64'(0));
    run("ill prio", 1'b0, 1'b0, 32'h101, 64'h0, 3'b111, 64'h0, mk(64'h0, 1'b1, 2'b01, 1));

    m_ready = 1'b0;
    run("TMO", 1'b0, 1'b0, 32'h200, 64'h0, 3'b010, 64'h12345678, mk(64'h0, 1'b1, 2'b11, 17));
    chk("TMO bus_valid cycles", 64'(nbus), 64'(16));
    m_ready = 1'b1;
    @(negedge clk);
    m_force = 1'b1;
    @(negedge clk);
    m_force = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (c32.rsp_valid || c32.stall || m32.bus_valid) cnt++;
      @(negedge clk);
    end
    chk("idle rvalid ignored", 64'(cnt), 64'(0));

    m_err = 1'b1;
    run("BUSERR", 1'b0, 1'b0, 32'h104, 64'h0, 3'b010, 64'h12345678, mk(64'h0, 1'b1, 2'b10, 3));
    m_err = 1'b0;
    run("LW ok", 1'b0, 1'b0, 32'h104, 64'h0, 3'b010, 64'h12345678, mk(64'h12345678, 1'b0, 2'b00, 3));

    m_auto = 1'b0;
    @(negedge clk);
    t_sel = 1'b0; t_we = 1'b0; t_addr = 32'h100; t_size = 3'b010; t_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("DATA stall", 64'(c32.stall), 64'(1));
    chk("DATA be held", 64'(m32.bus_be), 64'hF);
    t_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async rst be",    64'(m32.bus_be), 64'(0));
    chk("async rst addr",  64'(m32.bus_addr), 64'(0));
    chk("async rst stall", 64'(c32.stall), 64'(0));
    chk("async rst rsp",   64'(c32.rsp_valid), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    m_auto = 1'b1;
    run("LW post rst", 1'b0, 1'b0, 32'h100, 64'h0, 3'b010, 64'hCAFEF00D, mk(64'hCAFEF00D, 1'b0, 2'b00, 3));

    run("SD64", 1'b1, 1'b1, 32'h8, 64'h1122334455667788, 3'b011, 64'h0, mk(64'h0, 1'b0, 2'b00, 3));
    chk("SD64 bus_be",    64'(cap_be), 64'hFF);
    chk("SD64 bus_addr",  64'(cap_addr), 64'h8);
    chk("SD64 bus_wdata", cap_wdata, 64'h1122334455667788);
    run("LW64", 1'b1, 1'b0, 32'hC, 64'h0, 3'b010, 64'h80000000_00000000,
        mk(64'hFFFFFFFF_80000000, 1'b0, 2'b00, 3));
    chk("LW64 bus_addr", 64'(cap_addr), 64'h8);
    run("LWU64", 1'b1, 1'b0, 32'hC, 64'h0, 3'b110, 64'h80000000_00000000,
        mk(64'h00000000_80000000, 1'b0, 2'b00, 3));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
